// File: rtl/product_bcd_display_pkg.sv
// Shared definitions for the product BCD display block.
// Provides the conversion FSM state type, the 7-segment patterns in
// {a,b,c,d,e,f,g} order (active-high), the digit count and the
// double-dabble nibble adjust helper.
package product_bcd_display_pkg;

   localparam int unsigned NUM_DIGITS = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Add 3 to every nibble that is >= 5. A nibble is at most 9 before the
   // adjust, so the 4-bit sum never carries into the next nibble.
   function automatic logic [19:0] bcd_adjust(input logic [19:0] v);
      logic [19:0] r;
      r = v;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/product_bcd_display_seg7.sv
// Combinational BCD nibble to 7-segment decoder.
// Ports:
//   nibble  in  4  BCD digit value
//   blank   in  1  1 = force all segments off
//   seg     out 7  {a,b,c,d,e,f,g}, active-high
// Values above 9 cannot occur from the converter; they show a dash.
module bcd_to_seg7
   import product_bcd_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/product_bcd_display.sv
// Captures a 16-bit multiplier product on a load strobe, converts it to
// five BCD digits with a sequential double-dabble and scans the digits
// onto a single 7-segment bus.
// Ports:
//   clk         in   1   system clock, rising edge
//   reset_a     in   1   synchronous, active-high reset
//   product_in  in   16  unsigned binary product
//   load        in   1   1-cycle capture strobe (ignored while busy)
//   busy        out  1   high while a conversion is in progress
//   bcd_valid   out  1   1-cycle pulse when bcd_out has just been updated
//   bcd_out     out  20  {d4,d3,d2,d1,d0} BCD nibbles, d0 = units
//   digit_sel   out  5   one-hot digit enable, active-high
//   seg         out  7   {a,b,c,d,e,f,g} for the selected digit, active-high
// Parameters:
//   SCAN_DIV    clk cycles per displayed digit (>= 2)
//   BLANK_LZ    1 = blank leading zeros above the units digit
module product_bcd_display
   import product_bcd_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000,
   parameter bit          BLANK_LZ = 1'b1
)
(
   input  logic        clk,
   input  logic        reset_a,
   input  logic [15:0] product_in,
   input  logic        load,
   output logic        busy,
   output logic        bcd_valid,
   output logic [19:0] bcd_out,
   output logic [4:0]  digit_sel,
   output logic [6:0]  seg
);

   localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESCALE_TC = PW'(SCAN_DIV - 1);

   state_t      state;
   logic [15:0] bin_sr;
   logic [19:0] bcd_sr;
   logic [3:0]  iter;

   logic [PW-1:0] prescale;
   logic [2:0]    scan_idx;
   logic [2:0]    next_idx;
   logic          prescale_tc;
   logic [4:0]    lz_mask;
   logic [3:0]    mux_nibble;
   logic          mux_blank;
   logic [6:0]    dec_seg;

   // ---------------------------------------------------------------
   // Conversion FSM and shift register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset_a) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         bcd_valid <= 1'b0;
         bcd_out   <= '0;
         bin_sr    <= '0;
         bcd_sr    <= '0;
         iter      <= '0;
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  bin_sr <= product_in;
                  bcd_sr <= '0;
                  iter   <= '0;
                  busy   <= 1'b1;
                  state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Adjust first, then shift: after the 16th shift bcd_sr
               // holds the final digits with no trailing adjust needed.
               {bcd_sr, bin_sr} <= {bcd_adjust(bcd_sr), bin_sr} << 1;
               iter <= iter + 4'd1;
               if (iter == 4'd15) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               bcd_out   <= bcd_sr;
               bcd_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Scan index, leading-zero mask and digit mux
   // ---------------------------------------------------------------
   always_comb begin
      prescale_tc = (prescale == PRESCALE_TC);
      next_idx    = scan_idx;
      if (prescale_tc) begin
         next_idx = (scan_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
      end
   end

   // lz_mask[k] is set when digit k and every digit above it are zero.
   // The units digit is never part of the mask.
   always_comb begin
      logic zero_above;
      int unsigned k;
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
         k          = NUM_DIGITS - 1 - i;
         zero_above = zero_above & (bcd_out[4*k +: 4] == 4'd0);
         lz_mask[k] = zero_above;
      end
   end

   always_comb begin
      mux_nibble = bcd_out[3:0];
      mux_blank  = 1'b0;
      case (next_idx)
         3'd0: mux_nibble = bcd_out[3:0];
         3'd1: mux_nibble = bcd_out[7:4];
         3'd2: mux_nibble = bcd_out[11:8];
         3'd3: mux_nibble = bcd_out[15:12];
         3'd4: mux_nibble = bcd_out[19:16];
         default: mux_nibble = bcd_out[3:0];
      endcase
      case (next_idx)
         3'd1: mux_blank = BLANK_LZ & lz_mask[1];
         3'd2: mux_blank = BLANK_LZ & lz_mask[2];
         3'd3: mux_blank = BLANK_LZ & lz_mask[3];
         3'd4: mux_blank = BLANK_LZ & lz_mask[4];
         default: mux_blank = 1'b0;
      endcase
   end

   bcd_to_seg7 u_seg7 (
      .nibble (mux_nibble),
      .blank  (mux_blank),
      .seg    (dec_seg)
   );

   // digit_sel and seg are registered from the next index so both change
   // on the same edge as the index itself.
   always_ff @(posedge clk) begin
      if (reset_a) begin
         prescale  <= '0;
         scan_idx  <= '0;
         digit_sel <= 5'b00001;
         seg       <= SEG_0;
      end else begin
         prescale  <= prescale_tc ? '0 : prescale + 1'b1;
         scan_idx  <= next_idx;
         digit_sel <= 5'b00001 << next_idx;
         seg       <= dec_seg;
      end
   end

endmodule
